// File: rtl/rwl_pulse_driver_if.sv
// Request/response bundle between the row controller and the RWL driver strip.
// master = controller side, slave = driver side.
interface rwl_pulse_driver_if #(
  parameter int ROWS = 256,
  parameter int AW   = 8,
  parameter int PW_W = 4
);
  logic            req_valid;
  logic            req_ready;
  logic            req_multi;
  logic [AW-1:0]   req_addr;
  logic [ROWS-1:0] req_mask;
  logic [PW_W-1:0] req_pw;
  logic [PW_W-1:0] req_gap;
  logic [ROWS-1:0] rwl;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output req_valid, req_multi, req_addr, req_mask, req_pw, req_gap,
    input  req_ready, rwl, busy, done, err
  );

  modport slave (
    input  req_valid, req_multi, req_addr, req_mask, req_pw, req_gap,
    output req_ready, rwl, busy, done, err
  );
endinterface

// File: rtl/rwl_pulse_driver.sv
// Read-word-line driver strip: one request at a time, registered RWL pulse of
// programmable width, programmable recovery gap, then a DONE/ERR strobe.
module rwl_pulse_driver #(
  parameter int ROWS = 256,
  parameter int AW   = 8,
  parameter int PW_W = 4
) (
  input  logic                clk,
  input  logic                rstn,
  rwl_pulse_driver_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOVER} state_e;

  localparam logic [AW:0] ROWS_LIM = (AW+1)'(ROWS);

  state_e          state_q, state_d;
  logic            accept;
  logic            multi_q;
  logic [AW-1:0]   addr_q;
  logic [ROWS-1:0] mask_q;
  logic [PW_W-1:0] pw_m1_q, gap_m1_q, cnt_q;
  logic            err_q;
  logic [ROWS-1:0] rwl_q;
  logic [ROWS-1:0] row_vec;
  logic            addr_oor;

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign addr_oor = {1'b0, addr_q} >= ROWS_LIM;

  // Out-of-range addresses match no row index, so they decode to all-zero.
  always_comb begin
    row_vec = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_vec[i] = multi_q ? mask_q[i] : (addr_q == AW'(i));
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = PULSE;
      PULSE:   if (cnt_q == '0) state_d = RECOVER;
      RECOVER: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the capture registers are reset along with the control state so
  // no unknown value can ever reach the decoder or the word lines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      multi_q  <= 1'b0;
      addr_q   <= '0;
      mask_q   <= '0;
      pw_m1_q  <= '0;
      gap_m1_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rwl_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            multi_q  <= bus.req_multi;
            addr_q   <= bus.req_addr;
            mask_q   <= bus.req_mask;
            pw_m1_q  <= (bus.req_pw  == '0) ? '0 : bus.req_pw  - PW_W'(1);
            gap_m1_q <= (bus.req_gap == '0) ? '0 : bus.req_gap - PW_W'(1);
          end
        end
        SETUP: begin
          rwl_q <= row_vec;
          err_q <= !multi_q && addr_oor;
          cnt_q <= pw_m1_q;
        end
        PULSE: begin
          if (cnt_q == '0) begin
            rwl_q <= '0;
            cnt_q <= gap_m1_q;
          end else begin
            cnt_q <= cnt_q - PW_W'(1);
          end
        end
        RECOVER: begin
          if (cnt_q != '0) cnt_q <= cnt_q - PW_W'(1);
        end
        default: rwl_q <= '0;
      endcase
    end
  end

  // Status outputs decode from registered state only.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rwl       = rwl_q;
  assign bus.done      = (state_q == RECOVER) && (cnt_q == '0);
  assign bus.err       = bus.done && err_q;

endmodule
